// File: rtl/neuron_mac_sequencer.sv
// Neuron MAC sequencer: walks SEL over the weight slots and then the offset slot, accumulating
// Q-format products into one pre-activation Result. Define NEURON_MAC_SAT_EN for a saturating result.
module neuron_mac_sequencer #(
    parameter int Width     = 16,
    parameter int FracBits  = 8,
    parameter int NumInputs = 20,
    parameter int OffsetSel = 20
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    Start,
    input  logic signed [Width-1:0] CoeffIn,
    input  logic signed [Width-1:0] DataIn,
    output logic        [4:0]       SEL,
    output logic                    Busy,
    output logic                    Done,
    output logic signed [Width-1:0] Result
);

    localparam int AccW  = 2 * Width + 5;
    localparam int ProdW = 2 * Width;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_OFFSET = 2'd2
    } state_t;

    state_t                  r_state;
    logic        [4:0]       r_sel;
    logic                    r_busy;
    logic                    r_done;
    logic        [Width-1:0] r_result;
    logic signed [AccW-1:0]  r_acc;

    logic signed [ProdW-1:0] w_prod;
    logic signed [ProdW-1:0] w_term;
    logic signed [AccW-1:0]  w_term_ext;
    logic        [Width-1:0] w_fit;

    // Full-precision product, floored back to Q format by the arithmetic shift.
    assign w_prod     = ProdW'(CoeffIn) * ProdW'(DataIn);
    assign w_term     = w_prod >>> FracBits;
    assign w_term_ext = AccW'(w_term);

`ifdef NEURON_MAC_SAT_EN
    logic signed [AccW-1:0] w_sum;

    function automatic logic [Width-1:0] sat_fit(input logic signed [AccW-1:0] v);
        logic [Width-1:0] fit_v;
        if (v[AccW-1:Width-1] == {(AccW-Width+1){v[AccW-1]}}) begin
            fit_v = v[Width-1:0];
        end else if (v[AccW-1]) begin
            fit_v = {1'b1, {(Width-1){1'b0}}};
        end else begin
            fit_v = {1'b0, {(Width-1){1'b1}}};
        end
        return fit_v;
    endfunction

    assign w_sum = r_acc + AccW'(CoeffIn);
    assign w_fit = sat_fit(w_sum);
`else
    // Only the low bits of the sum survive wrapping, so only low operand bits are needed.
    assign w_fit = r_acc[Width-1:0] + CoeffIn;
`endif

    // Sequencer FSM with registered SEL, Busy, Done and Result.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {Width{1'b0}};
            r_acc    <= {AccW{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sel <= 5'd0;
                    if (Start) begin
                        r_state <= S_MAC;
                        r_acc   <= {AccW{1'b0}};
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term_ext;
                    if (r_sel == 5'(NumInputs - 1)) begin
                        r_sel   <= 5'(OffsetSel);
                        r_state <= S_OFFSET;
                    end else begin
                        r_sel <= r_sel + 5'd1;
                    end
                end
                S_OFFSET: begin
                    r_result <= w_fit;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_sel    <= 5'd0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= 5'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign SEL    = r_sel;
    assign Busy   = r_busy;
    assign Done   = r_done;
    assign Result = r_result;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench for neuron_mac_sequencer: vector table, random evaluations against an
// arithmetic reference model, and hand sequences for re-start, back-to-back, reset and NumInputs=3.
module tb_neuron_mac_sequencer;

    localparam int NI = 20;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start3;
    logic [15:0] coef_tab [0:31];
    logic [15:0] data_tab [0:31];

    logic [4:0]  sel, sel3;
    logic        busy, busy3, done, done3;
    logic [15:0] result, result3;
    logic [15:0] coeff_in, data_in, coeff_in3, data_in3;

    int checks   = 0;
    int failures = 0;

    // Register-bank and feature muxes modelled combinationally on SEL.
    assign coeff_in  = coef_tab[sel];
    assign data_in   = data_tab[sel];
    assign coeff_in3 = coef_tab[sel3];
    assign data_in3  = data_tab[sel3];

    neuron_mac_sequencer #(.Width(16), .FracBits(8), .NumInputs(NI), .OffsetSel(20)) dut (
        .CLK(clk), .reset(reset), .Start(start), .CoeffIn(coeff_in), .DataIn(data_in),
        .SEL(sel), .Busy(busy), .Done(done), .Result(result)
    );

    neuron_mac_sequencer #(.Width(16), .FracBits(8), .NumInputs(3), .OffsetSel(20)) dut3 (
        .CLK(clk), .reset(reset), .Start(start3), .CoeffIn(coeff_in3), .DataIn(data_in3),
        .SEL(sel3), .Busy(busy3), .Done(done3), .Result(result3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] coeff;
        logic [15:0] data;
        logic [15:0] offset;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fill(input logic [15:0] c, input logic [15:0] d, input logic [15:0] o);
        for (int i = 0; i < 32; i++) begin
            coef_tab[i] = c;
            data_tab[i] = d;
        end
        coef_tab[20] = o;
    endtask

    // Sum of floored Q8 products plus the offset, then wrap or clamp to 16 bits.
    function automatic logic [15:0] model(input int n);
        longint acc;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            acc += (longint'($signed(coef_tab[i])) * longint'($signed(data_tab[i]))) >>> 8;
        end
        acc += longint'($signed(coef_tab[20]));
`ifdef NEURON_MAC_SAT_EN
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
`endif
        return acc[15:0];
    endfunction

    // One evaluation on the 20-input DUT; optional extra Start pulse during cycle pulse_cyc.
    task automatic eval_main(input string nm, input logic [15:0] exp_res, input int pulse_cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= NI + 5; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            start = (c == pulse_cyc);
            @(negedge clk);
            if (c <= NI) begin
                chk({nm, " sel"}, int'(sel), c - 1);
                chk({nm, " busy"}, int'(busy), 1);
                chk({nm, " done"}, int'(done), 0);
            end else if (c == NI + 1) begin
                chk({nm, " sel_ofs"}, int'(sel), 20);
                chk({nm, " busy_ofs"}, int'(busy), 1);
                chk({nm, " done_ofs"}, int'(done), 0);
            end else if (c == NI + 2) begin
                chk({nm, " done_pulse"}, int'(done), 1);
                chk({nm, " busy_at_done"}, int'(busy), 0);
                chk({nm, " sel_at_done"}, int'(sel), 0);
                chk({nm, " result"}, int'(result), int'(exp_res));
            end else begin
                chk({nm, " done_after"}, int'(done), 0);
                chk({nm, " busy_after"}, int'(busy), 0);
                chk({nm, " result_hold"}, int'(result), int'(exp_res));
            end
        end
    endtask

    logic [15:0] exp_v;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        fill(16'h0000, 16'h0000, 16'h0000);

        vecs[0] = '{16'h0100, 16'h0080, 16'h0040, 16'h0A40};
        vecs[1] = '{16'hFF00, 16'h0100, 16'h0000, 16'hEC00};
        vecs[2] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFEC};
`ifdef NEURON_MAC_SAT_EN
        vecs[3] = '{16'h4000, 16'h4000, 16'h0000, 16'h7FFF};
        vecs[4] = '{16'hC000, 16'h4000, 16'h0000, 16'h8000};
`else
        vecs[3] = '{16'h4000, 16'h4000, 16'h0000, 16'h0000};
        vecs[4] = '{16'hC000, 16'h4000, 16'h0000, 16'h0000};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst sel", int'(sel), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst result", int'(result), 0);
        chk("rst sel3", int'(sel3), 0);
        chk("rst result3", int'(result3), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle busy", int'(busy), 0);
        chk("idle done", int'(done), 0);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].coeff, vecs[v].data, vecs[v].offset);
            eval_main($sformatf("vec%0d", v), vecs[v].exp, 0);
        end

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 32; i++) begin
                if (r % 2 == 0) begin
                    coef_tab[i] = 16'($urandom);
                    data_tab[i] = 16'($urandom);
                end else begin
                    coef_tab[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                    data_tab[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
                end
            end
            exp_v = model(NI);
            eval_main($sformatf("rand%0d", r), exp_v, 0);
        end

        // Start re-pulsed while SEL shows 5 must be ignored.
        fill(16'h0100, 16'h0080, 16'h0040);
        eval_main("repulse", 16'h0A40, 6);

        // Start held high across Done: period of NI+2 cycles, two identical results.
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= 2 * (NI + 2) + 3; c++) begin
            @(posedge clk); #1;
            start = (c < 2 * (NI + 2));
            @(negedge clk);
            if (c <= 2 * (NI + 2)) begin
                int p;
                p = (c - 1) % (NI + 2);
                chk("b2b sel", int'(sel), (p < NI) ? p : ((p == NI) ? 20 : 0));
                chk("b2b busy", int'(busy), (p <= NI) ? 1 : 0);
                chk("b2b done", int'(done), (p == NI + 1) ? 1 : 0);
                if (p == NI + 1) chk("b2b result", int'(result), 16'h0A40);
            end else begin
                chk("b2b idle busy", int'(busy), 0);
                chk("b2b idle done", int'(done), 0);
            end
        end

        // One-cycle reset while SEL shows 7 discards the evaluation.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 8) reset = 1'b1;
        end
        @(negedge clk);
        chk("rstmid sel_before", int'(sel), 7);
        chk("rstmid result_before", int'(result), 16'h0A40);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid sel", int'(sel), 0);
        chk("rstmid busy", int'(busy), 0);
        chk("rstmid done", int'(done), 0);
        chk("rstmid result", int'(result), 0);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            chk("rstmid no_done", int'(done), 0);
            chk("rstmid stay_idle", int'(busy), 0);
        end
        eval_main("after_rst", 16'h0A40, 0);

        // NumInputs=3 instance: SEL 0,1,2,20 and Done 5 cycles after the Start edge.
        fill(16'h0100, 16'h0200, 16'hFF00);
        chk("n3 model", int'(model(3)), 16'h0500);
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("n3 sel", int'(sel3), (c <= 3) ? c - 1 : ((c == 4) ? 20 : 0));
            chk("n3 busy", int'(busy3), (c <= 4) ? 1 : 0);
            chk("n3 done", int'(done3), (c == 5) ? 1 : 0);
            if (c >= 5) chk("n3 result", int'(result3), 16'h0500);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
